// File: rtl/rob_ptr_ctrl_pkg.sv
// Shared types and helpers for the re-order buffer pointer/occupancy controller.
package rob_ptr_ctrl_pkg;

  localparam int unsigned ROB_DEPTH  = 16;
  localparam int unsigned ROB_IDX_W  = 4;
  localparam int unsigned ROB_NUM_FU = 3;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [ROB_IDX_W:0]   rob_cnt_t;
  typedef logic [ROB_DEPTH-1:0] rob_map_t;

  typedef enum logic [1:0] {
    RC_IDLE,
    RC_RUN,
    RC_DONE
  } rob_ctrl_state_e;

  // Pointers wrap naturally because ROB_DEPTH is a power of two.
  function automatic rob_idx_t rob_idx_inc(rob_idx_t idx, logic [1:0] n);
    return idx + rob_idx_t'(n);
  endfunction

endpackage

// File: rtl/rob_ptr_ctrl_if.sv
// Dispatch / completion / retirement signal bundle of the ROB pointer controller.
interface rob_ptr_ctrl_if;
  import rob_ptr_ctrl_pkg::*;

  logic        start_i;
  logic [31:0] tot_instr_i;
  logic        flush_i;
  logic [1:0]  alloc_valid_i;
  logic        alloc_ready_o;
  rob_idx_t    alloc_idx0_o;
  rob_idx_t    alloc_idx1_o;
  logic [2:0]  comp_valid_i;
  rob_idx_t    comp_idx0_i;
  rob_idx_t    comp_idx1_i;
  rob_idx_t    comp_idx2_i;
  logic        retire_stall_i;
  logic [1:0]  retire_valid_o;
  rob_idx_t    retire_idx0_o;
  rob_idx_t    retire_idx1_o;
  rob_cnt_t    count_o;
  logic        full_o;
  logic        empty_o;
  logic [31:0] retired_o;
  logic        done_o;
  logic        err_o;

  modport master (
    output start_i, tot_instr_i, flush_i, alloc_valid_i, comp_valid_i,
           comp_idx0_i, comp_idx1_i, comp_idx2_i, retire_stall_i,
    input  alloc_ready_o, alloc_idx0_o, alloc_idx1_o, retire_valid_o,
           retire_idx0_o, retire_idx1_o, count_o, full_o, empty_o,
           retired_o, done_o, err_o
  );

  modport slave (
    input  start_i, tot_instr_i, flush_i, alloc_valid_i, comp_valid_i,
           comp_idx0_i, comp_idx1_i, comp_idx2_i, retire_stall_i,
    output alloc_ready_o, alloc_idx0_o, alloc_idx1_o, retire_valid_o,
           retire_idx0_o, retire_idx1_o, count_o, full_o, empty_o,
           retired_o, done_o, err_o
  );

endinterface

// File: rtl/rob_ptr_ctrl.sv
// Head/tail pointers, valid/complete bitmaps and occupancy for the 16-entry ROB.
module rob_ptr_ctrl
  import rob_ptr_ctrl_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_n_i,
  rob_ptr_ctrl_if.slave  bus
);

  rob_ctrl_state_e state_q, state_d;
  rob_map_t        valid_q, valid_d;
  rob_map_t        comp_q,  comp_d;
  rob_idx_t        head_q,  head_d;
  rob_idx_t        tail_q,  tail_d;
  rob_cnt_t        count_q, count_d;
  logic [31:0]     retired_q, retired_d;
  logic            err_q,   err_d;

  logic            run;
  logic            ready;
  logic            rv0, rv1;
  logic [1:0]      nret;
  logic [1:0]      nalloc;
  rob_idx_t        head1, tail1;
  rob_idx_t        comp_idx [ROB_NUM_FU];

  assign comp_idx[0] = bus.comp_idx0_i;
  assign comp_idx[1] = bus.comp_idx1_i;
  assign comp_idx[2] = bus.comp_idx2_i;

  assign run   = (state_q == RC_RUN);
  assign head1 = rob_idx_inc(head_q, 2'd1);
  assign tail1 = rob_idx_inc(tail_q, 2'd1);
  assign ready = run && (count_q <= rob_cnt_t'(ROB_DEPTH - 2));

  // Retirement looks only at registered state, never at this cycle's completions.
  assign rv0  = run && !bus.retire_stall_i && valid_q[head_q] && comp_q[head_q];
  assign rv1  = rv0 && valid_q[head1] && comp_q[head1];
  assign nret = {1'b0, rv0} + {1'b0, rv1};

  always_comb begin
    nalloc = 2'd0;
    if (ready) begin
      unique case (bus.alloc_valid_i)
        2'b01:   nalloc = 2'd1;
        2'b11:   nalloc = 2'd2;
        default: nalloc = 2'd0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    comp_d    = comp_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    retired_d = retired_q;
    err_d     = err_q;

    for (int unsigned k = 0; k < ROB_NUM_FU; k++) begin
      if (bus.comp_valid_i[k]) begin
        if (valid_q[comp_idx[k]]) comp_d[comp_idx[k]] = 1'b1;
        else                      err_d = 1'b1;
      end
    end
    if (bus.alloc_valid_i == 2'b10) err_d = 1'b1;

    if (rv0) begin
      valid_d[head_q] = 1'b0;
      comp_d[head_q]  = 1'b0;
    end
    if (rv1) begin
      valid_d[head1] = 1'b0;
      comp_d[head1]  = 1'b0;
    end
    // Allocation only ever targets invalid slots, so it is applied last without conflict.
    if (nalloc != 2'd0) begin
      valid_d[tail_q] = 1'b1;
      comp_d[tail_q]  = 1'b0;
    end
    if (nalloc == 2'd2) begin
      valid_d[tail1] = 1'b1;
      comp_d[tail1]  = 1'b0;
    end

    head_d    = rob_idx_inc(head_q, nret);
    tail_d    = rob_idx_inc(tail_q, nalloc);
    count_d   = count_q + rob_cnt_t'(nalloc) - rob_cnt_t'(nret);
    retired_d = retired_q + 32'(nret);

    unique case (state_q)
      RC_IDLE: if (bus.start_i) state_d = RC_RUN;
      RC_RUN:  if ((bus.tot_instr_i != '0) && (retired_d == bus.tot_instr_i)) state_d = RC_DONE;
      default: state_d = state_q;
    endcase

    if (bus.flush_i) begin
      valid_d   = '0;
      comp_d    = '0;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      retired_d = retired_q;
      err_d     = err_q;
      state_d   = state_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= RC_IDLE;
      valid_q   <= '0;
      comp_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      comp_q    <= comp_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

  assign bus.alloc_ready_o  = ready;
  assign bus.alloc_idx0_o   = tail_q;
  assign bus.alloc_idx1_o   = tail1;
  assign bus.retire_valid_o = {rv1, rv0};
  assign bus.retire_idx0_o  = head_q;
  assign bus.retire_idx1_o  = head1;
  assign bus.count_o        = count_q;
  assign bus.full_o         = (count_q == rob_cnt_t'(ROB_DEPTH));
  assign bus.empty_o        = (count_q == '0);
  assign bus.retired_o      = retired_q;
  assign bus.done_o         = (state_q == RC_DONE);
  assign bus.err_o          = err_q;

endmodule

// File: tb/tb_rob_ptr_ctrl.sv
// Directed and random checks of rob_ptr_ctrl against a queue-based ROB occupancy model.
module tb_rob_ptr_ctrl;
  import rob_ptr_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rob_ptr_ctrl_if bus();

  rob_ptr_ctrl dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  // Model: program-order queue of occupied ROB indices plus per-index completion marks.
  int          q[$];
  bit          cdone [16];
  int          m_head;
  int unsigned m_retired;
  int unsigned m_tot;
  bit          m_err, m_started, m_finished;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_tail();
    return (m_head + q.size()) % 16;
  endfunction

  task automatic model_reset();
    q.delete();
    foreach (cdone[i]) cdone[i] = 1'b0;
    m_head = 0; m_retired = 0; m_err = 0; m_started = 0; m_finished = 0;
  endtask

  task automatic set_tot(input int unsigned v);
    bus.tot_instr_i = v;
    m_tot = v;
  endtask

  task automatic drive_idle();
    bus.start_i = 1'b0; bus.flush_i = 1'b0; bus.alloc_valid_i = 2'b00;
    bus.comp_valid_i = 3'b000; bus.comp_idx0_i = '0; bus.comp_idx1_i = '0;
    bus.comp_idx2_i = '0; bus.retire_stall_i = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    int t;
    t = m_tail();
    chk({tag, ".count"},   32'(bus.count_o),       32'(q.size()));
    chk({tag, ".full"},    32'(bus.full_o),        32'(q.size() == 16));
    chk({tag, ".empty"},   32'(bus.empty_o),       32'(q.size() == 0));
    chk({tag, ".retired"}, bus.retired_o,          m_retired);
    chk({tag, ".done"},    32'(bus.done_o),        32'(m_finished));
    chk({tag, ".err"},     32'(bus.err_o),         32'(m_err));
    chk({tag, ".tail"},    32'(bus.alloc_idx0_o),  32'(t));
    chk({tag, ".tail1"},   32'(bus.alloc_idx1_o),  32'((t + 1) % 16));
    chk({tag, ".head"},    32'(bus.retire_idx0_o), 32'(m_head));
    chk({tag, ".head1"},   32'(bus.retire_idx1_o), 32'((m_head + 1) % 16));
  endtask

  task automatic cycle(input bit start, input bit flush, input logic [1:0] mask,
                       input logic [2:0] cv, input int c0, input int c1, input int c2,
                       input bit stall, input string tag);
    bit running, ready, rv0, rv1, found;
    int nret, nnew;
    int cidx [3];
    @(negedge clk);
    bus.start_i = start; bus.flush_i = flush; bus.alloc_valid_i = mask;
    bus.comp_valid_i = cv; bus.comp_idx0_i = c0[3:0]; bus.comp_idx1_i = c1[3:0];
    bus.comp_idx2_i = c2[3:0]; bus.retire_stall_i = stall;
    #1;
    running = m_started && !m_finished;
    ready   = running && (16 - q.size() >= 2);
    rv0     = running && !stall && (q.size() >= 1) && cdone[q[0]];
    rv1     = rv0 && (q.size() >= 2) && cdone[q[1]];
    chk({tag, ".ready"}, 32'(bus.alloc_ready_o), 32'(ready));
    chk({tag, ".rv"},    32'(bus.retire_valid_o), 32'({rv1, rv0}));
    nret = int'(rv0) + int'(rv1);
    if (flush) begin
      q.delete();
      foreach (cdone[i]) cdone[i] = 1'b0;
      m_head = 0;
    end else begin
      if (mask == 2'b10) m_err = 1;
      cidx[0] = c0; cidx[1] = c1; cidx[2] = c2;
      for (int k = 0; k < 3; k++) begin
        if (cv[k]) begin
          found = 0;
          foreach (q[j]) if (q[j] == cidx[k]) found = 1;
          if (found) cdone[cidx[k]] = 1'b1;
          else       m_err = 1;
        end
      end
      repeat (nret) void'(q.pop_front());
      m_head = (m_head + nret) % 16;
      nnew = !ready ? 0 : (mask == 2'b11) ? 2 : (mask == 2'b01) ? 1 : 0;
      for (int a = 0; a < nnew; a++) begin
        cdone[m_tail()] = 1'b0;
        q.push_back(m_tail());
      end
      m_retired += nret;
      if (running && m_tot != 0 && m_retired == m_tot) m_finished = 1;
      if (!m_started && start) m_started = 1;
    end
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  task automatic idle(input string tag);
    cycle(0, 0, 2'b00, 3'b000, 0, 0, 0, 0, tag);
  endtask

  task automatic alloc(input logic [1:0] mask, input string tag);
    cycle(0, 0, mask, 3'b000, 0, 0, 0, 0, tag);
  endtask

  // Reset is dropped mid-cycle so the outputs must react without any clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    drive_idle();
    #1;
    model_reset();
    chk({tag, ".ready"}, 32'(bus.alloc_ready_o), 32'(0));
    chk({tag, ".rv"},    32'(bus.retire_valid_o), 32'(0));
    check_regs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned saved_ret;
    int cv_bits, i0, i1, i2;
    logic [1:0] rmask;
    drive_idle();
    model_reset();
    set_tot(1000);
    #12;
    chk("rst.ready", 32'(bus.alloc_ready_o), 32'(0));
    chk("rst.rv",    32'(bus.retire_valid_o), 32'(0));
    check_regs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill the ROB completely with no completions.
    cycle(1, 0, 2'b00, 3'b000, 0, 0, 0, 0, "t1.start");
    repeat (8) alloc(2'b11, "t1.alloc");
    chk("t1.full_o",  32'(bus.full_o), 32'(1));
    chk("t1.count_o", 32'(bus.count_o), 32'(16));
    chk("t1.ready_o", 32'(bus.alloc_ready_o), 32'(0));
    chk("t1.tail_o",  32'(bus.alloc_idx0_o), 32'(0));
    alloc(2'b11, "t1.hold");

    // Out-of-order completion holds retirement until the head completes.
    cycle(0, 1, 2'b00, 3'b000, 0, 0, 0, 0, "t2.flush");
    repeat (2) alloc(2'b11, "t2.alloc");
    cycle(0, 0, 2'b00, 3'b011, 1, 3, 0, 0, "t2.c13");
    cycle(0, 0, 2'b00, 3'b001, 0, 0, 0, 0, "t2.c0");
    idle("t2.ret");
    chk("t2.head_o", 32'(bus.retire_idx0_o), 32'(2));

    // Walk head to 15 and retire a pair that spans the wrap.
    cycle(0, 1, 2'b00, 3'b000, 0, 0, 0, 0, "t3.flush");
    repeat (7) alloc(2'b11, "t3.alloc");
    alloc(2'b01, "t3.alloc1");
    for (int b = 0; b < 15; b += 3) cycle(0, 0, 2'b00, 3'b111, b, b + 1, b + 2, 0, "t3.comp");
    for (int i = 0; i < 20 && q.size() != 0; i++) idle("t3.drain");
    chk("t3.head15", 32'(bus.retire_idx0_o), 32'(15));
    alloc(2'b11, "t3.alloc2");
    cycle(0, 0, 2'b00, 3'b011, 15, 0, 0, 0, "t3.c15_0");
    alloc(2'b01, "t3.wrap");
    chk("t3.head1",  32'(bus.retire_idx0_o), 32'(1));
    chk("t3.count1", 32'(bus.count_o), 32'(1));

    // Random traffic with legal masks and completions aimed at occupied entries.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 2))
        0:       rmask = 2'b00;
        1:       rmask = 2'b01;
        default: rmask = 2'b11;
      endcase
      cv_bits = 0; i0 = 0; i1 = 0; i2 = 0;
      if (q.size() != 0) begin
        cv_bits = int'($urandom_range(0, 7));
        i0 = q[$urandom_range(0, q.size() - 1)];
        i1 = q[$urandom_range(0, q.size() - 1)];
        i2 = q[$urandom_range(0, q.size() - 1)];
      end
      cycle(0, 0, rmask, cv_bits[2:0], i0, i1, i2, ($urandom_range(0, 4) == 0), "rand");
    end

    // Protocol errors.
    cycle(0, 1, 2'b00, 3'b000, 0, 0, 0, 0, "t4.flush");
    cycle(0, 0, 2'b00, 3'b001, 5, 0, 0, 0, "t4.badcomp");
    chk("t4.err_comp", 32'(bus.err_o), 32'(1));
    async_reset("t4.rst");
    cycle(1, 0, 2'b00, 3'b000, 0, 0, 0, 0, "t4.start");
    alloc(2'b10, "t4.badmask");
    chk("t4.err_mask", 32'(bus.err_o), 32'(1));
    chk("t4.tail0",    32'(bus.alloc_idx0_o), 32'(0));

    // Program completion and sticky done.
    async_reset("t5.rst");
    set_tot(4);
    cycle(1, 0, 2'b00, 3'b000, 0, 0, 0, 0, "t5.start");
    repeat (2) alloc(2'b11, "t5.alloc");
    cycle(0, 0, 2'b00, 3'b111, 0, 1, 2, 0, "t5.c012");
    cycle(0, 0, 2'b00, 3'b001, 3, 0, 0, 0, "t5.c3");
    idle("t5.ret");
    chk("t5.done_o", 32'(bus.done_o), 32'(1));
    alloc(2'b11, "t5.late");
    chk("t5.ready_o", 32'(bus.alloc_ready_o), 32'(0));

    // Flush overriding a same-cycle retire, then reset mid-run.
    async_reset("t6.rst");
    set_tot(1000);
    cycle(1, 0, 2'b00, 3'b000, 0, 0, 0, 0, "t6.start");
    repeat (3) alloc(2'b11, "t6.alloc");
    cycle(0, 0, 2'b00, 3'b011, 0, 1, 0, 0, "t6.c01");
    idle("t6.ret");
    cycle(0, 0, 2'b00, 3'b001, 2, 0, 0, 0, "t6.c2");
    saved_ret = m_retired;
    cycle(0, 1, 2'b00, 3'b000, 0, 0, 0, 0, "t6.flush");
    chk("t6.count0",  32'(bus.count_o), 32'(0));
    chk("t6.empty_o", 32'(bus.empty_o), 32'(1));
    chk("t6.retkeep", bus.retired_o, saved_ret);
    repeat (2) alloc(2'b11, "t6.refill");
    async_reset("t6.arst");
    idle("t6.post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
